// File: rtl/vga_sync_generator_pkg.sv
// vga_sync_generator shared raster constants and helpers.
// Single home for the 640x480@60 timing numbers.
package vga_sync_generator_pkg;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT
                           + H_SYNC + H_BACK;

  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT
                           + V_SYNC + V_BACK;

  localparam int CNT_W = 10;
  localparam int FC_W  = 8;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [FC_W-1:0]  fcnt_t;

  function automatic logic in_window(
    input cnt_t c,
    input int   lo,
    input int   len
  );
    return (int'(c) >= lo) && (int'(c) < lo + len);
  endfunction

endpackage

// File: rtl/vga_sync_generator_if.sv
// vga_sync_generator raster output bundle.
// master drives the raster, slave consumes it.
interface vga_sync_generator_if;
  import vga_sync_generator_pkg::*;

  cnt_t  h_count;
  cnt_t  v_count;
  logic  o_active;
  logic  o_line_tick;
  logic  o_frame_tick;
  fcnt_t o_frame_count;
  logic  o_hsync;
  logic  o_vsync;

  modport master (
    output h_count,
    output v_count,
    output o_active,
    output o_line_tick,
    output o_frame_tick,
    output o_frame_count,
    output o_hsync,
    output o_vsync
  );

  modport slave (
    input h_count,
    input v_count,
    input o_active,
    input o_line_tick,
    input o_frame_tick,
    input o_frame_count,
    input o_hsync,
    input o_vsync
  );

endinterface

// File: rtl/delay_line.sv
// delay_line: DEPTH-stage shift register, async reset.
// DEPTH of 0 degenerates to a wire.
module delay_line #(
  parameter int                WIDTH       = 1,
  parameter int                DEPTH       = 1,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  localparam int N = (DEPTH < 1) ? 1 : DEPTH;

  logic [WIDTH-1:0] stg [N];

  // Shift one stage per clock; reset discards anything in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N; i++) stg[i] <= RESET_VALUE;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < N; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = (DEPTH == 0) ? d : stg[N-1];

endmodule

// File: rtl/vga_sync_generator.sv
// vga_sync_generator: raster counters, strobes, delayed syncs.
// Timing defaults to the package 640x480 constants.
module vga_sync_generator
  import vga_sync_generator_pkg::*;
#(
  parameter int SYNC_DELAY      = 2,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int H_DISP = H_DISPLAY,
  parameter int H_FP   = H_FRONT,
  parameter int H_SW   = H_SYNC,
  parameter int H_BP   = H_BACK,
  parameter int V_DISP = V_DISPLAY,
  parameter int V_FP   = V_FRONT,
  parameter int V_SW   = V_SYNC,
  parameter int V_BP   = V_BACK
) (
  input logic                  CLK,
  input logic                  RST,
  vga_sync_generator_if.master vga
);

  localparam int H_TOT = H_DISP + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_DISP + V_FP + V_SW + V_BP;
  localparam int HS_LO = H_DISP + H_FP;
  localparam int VS_LO = V_DISP + V_FP;

  localparam cnt_t H_LAST = cnt_t'(H_TOT - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOT - 1);
  localparam cnt_t H_ACT  = cnt_t'(H_DISP);
  localparam cnt_t V_ACT  = cnt_t'(V_DISP);

  cnt_t       h_q;
  cnt_t       v_q;
  fcnt_t      fc_q;
  logic       h_wrap;
  logic       f_tick;
  logic [1:0] raw_sync;
  logic [1:0] dly_sync;

  // Decode strobes, active window and raw syncs from the counters.
  always_comb begin
    h_wrap      = (h_q == H_LAST);
    f_tick      = (h_q == '0) && (v_q == V_ACT);
    raw_sync[0] = in_window(h_q, HS_LO, H_SW);
    raw_sync[1] = in_window(v_q, VS_LO, V_SW);
  end

  // Pixel counter runs every clock; line counter steps on its wrap.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      h_q <= '0;
      v_q <= '0;
    end else if (h_wrap) begin
      h_q <= '0;
      v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end else begin
      h_q <= h_q + 1'b1;
    end
  end

  // Frame counter steps once per frame tick and wraps silently.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         fc_q <= '0;
    else if (f_tick) fc_q <= fc_q + 1'b1;
  end

  delay_line #(
    .WIDTH       (2),
    .DEPTH       (SYNC_DELAY),
    .RESET_VALUE (2'b00)
  ) u_sync_dly (
    .CLK (CLK),
    .RST (RST),
    .d   (raw_sync),
    .q   (dly_sync)
  );

  assign vga.h_count       = h_q;
  assign vga.v_count       = v_q;
  assign vga.o_active      = (h_q < H_ACT) && (v_q < V_ACT);
  assign vga.o_line_tick   = h_wrap;
  assign vga.o_frame_tick  = f_tick;
  assign vga.o_frame_count = fc_q;
  assign vga.o_hsync       = dly_sync[0] ^ SYNC_ACTIVE_LOW;
  assign vga.o_vsync       = dly_sync[1] ^ SYNC_ACTIVE_LOW;

endmodule

// File: doc/vga_sync_generator.md
# vga_sync_generator

Produces the 640x480 @ 60 Hz raster timing that the pixel and colour pipeline consumes: free-running horizontal and vertical counters, an active-video flag, frame and line strobes for the game logic, and HSYNC/VSYNC pulses. The sync pulses are delayed by a programmable number of cycles so they stay aligned with the registered sprite-ROM colour path downstream. It sits between the board clock and the colour generator, and its outputs are the only raster reference in the design.

## Interface
- SYNC_DELAY, 2: CLK cycles between the counter value and the matching HSYNC/VSYNC output. Equals the colour-path latency; legal range 0..7.
- SYNC_ACTIVE_LOW, 1: 1 drives sync pins low during the pulse; 0 drives them high.
- CLK  input  1  pixel clock, 25 MHz; all logic is on the rising edge.
- RST  input  1  reset; asynchronous, active-high.
- h_count  output  10  horizontal pixel position, 0..799.
- v_count  output  10  vertical line position, 0..524.
- o_active  output  1  high when h_count < H_DISPLAY and v_count < V_DISPLAY. Undelayed.
- o_line_tick  output  1  one-cycle pulse when h_count == H_TOTAL-1.
- o_frame_tick  output  1  one-cycle pulse at h_count == 0, v_count == V_DISPLAY, the start of vertical blanking.
- o_frame_count  output  8  frame counter; increments once per frame tick.
- o_hsync  output  1  horizontal sync, delayed by SYNC_DELAY.
- o_vsync  output  1  vertical sync, delayed by SYNC_DELAY.

## Operation
- Horizontal timing: 640 display, 16 front porch, 96 sync, 48 back porch. H_TOTAL is 800.
- Vertical timing: 480 display, 10 front porch, 2 sync, 33 back porch. V_TOTAL is 525.
- h_count increments every CLK. At 799 it wraps to 0.
- v_count increments only in the cycle where h_count wraps. When v_count is 524 and h_count wraps, both go to (0,0) together.
- Raw horizontal sync is asserted for h_count in 656..751 inclusive.
- Raw vertical sync is asserted for v_count in 490..491 inclusive, across every h_count on those lines.
- Raw syncs are combinational decodes of the registered counters. They feed a SYNC_DELAY-deep shift register; the last stage is registered and drives o_hsync/o_vsync.
- With SYNC_DELAY = 0, o_hsync/o_vsync are the raw decodes with polarity applied.
- Polarity is applied at the output: when SYNC_ACTIVE_LOW = 1, the pin is the inverse of the raw sync.
- o_active, o_line_tick and o_frame_tick are combinational decodes of the counters. They are not delayed.
- o_frame_count wraps 255 -> 0 with no flag.

## Timing
- Every output is a function of registered state only, so there are no combinational paths from any input.
- Reset values, held while RST is high:
  - h_count = 0, v_count = 0, o_frame_count = 0.
  - All delay stages hold "sync inactive", so o_hsync/o_vsync sit at the inactive level: 1 when SYNC_ACTIVE_LOW = 1.
  - o_active = 1, because the counters sit at (0,0).
  - o_line_tick = 0 and o_frame_tick = 0.
- The first counter increment happens on the first rising CLK edge after RST deasserts.
- RST asserted mid-frame: all state clears immediately (asynchronous). There is no partial-pulse completion.
- A sync pulse caught in the delay line at reset is discarded.
- At most one frame tick per 420,000 cycles.
- o_frame_tick and o_line_tick never coincide: line tick is at h = 799, frame tick is at h = 0.
- The o_frame_count increment is registered. The new value is visible in the cycle after o_frame_tick.
- Sync latency: the raw sync edge at counter value N appears on the pin exactly SYNC_DELAY cycles later.
  - Example, SYNC_DELAY = 2: o_hsync falls two cycles after h_count first equals 656.

## Structure
- H_DISPLAY, H_FRONT, H_SYNC, H_BACK, H_TOTAL and the V_* equivalents live in the shared constants.v. H_DISPLAY and V_DISPLAY are already there and stay the single source of truth.
- The sync boundaries are derived from those constants, never written as literals in this block.
- Sub-module: delay_line, parameterised by WIDTH and DEPTH, with asynchronous reset to a RESET_VALUE parameter.
  - Instantiated once, WIDTH = 2, carrying raw hsync and vsync.
  - Reusable by the colour path if its latency changes.

## Test plan
- Reset release: hold RST for 5 cycles, then release.
  - During reset: counters read 0, o_hsync = o_vsync = 1, o_active = 1.
  - The first edge after release: h_count = 1.
- Horizontal wrap, in two parts:
  - Run 800 cycles: h_count goes 799 -> 0; v_count goes 0 -> 1 on the same edge; o_line_tick is high only at h = 799.
  - With SYNC_DELAY = 2: o_hsync is low for exactly 96 cycles, falling at the edge two cycles after h_count reaches 656.
- Full frame: run 420,000 cycles.
  - o_vsync is low for exactly 1,600 cycles.
  - o_frame_tick pulses once, at (0,480).
  - o_frame_count goes 0 -> 1 on the next cycle.
  - Counters return to (0,0) at cycle 420,000.
- Active region: count o_active-high cycles over one frame; the count must be 307,200.
- Mid-frame reset: assert RST at (700,491) while vsync is active.
  - Outputs return at once to their reset values.
  - After release, the next vsync pulse starts only at v = 490.
- Parameter sweep: SYNC_DELAY = 0 and 5 with SYNC_ACTIVE_LOW = 0.
  - Pulse widths are unchanged; the pulses are active-high.
  - Offset from the raw decode is 0 and 5 cycles respectively.
- Counter wrap: run 256 frames; o_frame_count goes 255 -> 0.
